melody_seq: RTL and testbench
=============================

# melody_seq

Note sequencer that sits directly upstream of the I2S tone generator. It steps through a stored melody of (octave, note, duration) entries at a key-selectable tempo. It drives the generator's `octave`/`note` inputs, producing code 12 (silence) when stopped, paused or resting. It supports play/pause, restart, two tracks, optional looping and optional note articulation.

## Interface
- `BASE_DIV`, default 2^22: clock cycles per duration tick at tempo 0; must be a multiple of 8.
- `LOOP`, default 1: 1 = wrap to step 0 at the end marker; 0 = stop at the end marker.
- `ARTIC`, default 1: 1 = silence the final tick of every note with duration ≥ 2.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `play_toggle`  in  1  single-cycle pulse (debounced upstream); toggles between play and pause, or starts playback from stop.
- `restart`  in  1  single-cycle pulse; jump to step 0 and play.
- `tempo`  in  2  speed select; tick period = `BASE_DIV >> tempo` cycles.
- `track`  in  1  melody select (0/1).
- `octave`  out  3  registered octave for the tone generator.
- `note`  out  4  registered note code 0–11; 12 = silence.
- `playing`  out  1  high in PLAY state.
- `beat`  out  1  one-cycle pulse on every duration tick.
- `step`  out  6  index of the current melody entry.

## Operation
- ROM entry (12 bit) = {octave[2:0], note[3:0], dur[4:0]}, with dur in ticks.
  - dur = 0 is the end marker.
  - note = 12 inside an entry is a rest.
  - Depth is 64 entries per track.
- FSM states: STOP (reset state), PLAY, PAUSE.
  - STOP + play_toggle → PLAY at step 0.
  - PLAY + play_toggle → PAUSE.
  - PAUSE + play_toggle → PLAY.
  - Any state + restart → PLAY; step, tick prescaler and duration counter are cleared.
  - In PLAY, at the end marker: LOOP=1 → step 0, stay in PLAY. LOOP=0 → STOP with step 0.
- Priority: reset > restart > play_toggle. A restart and play_toggle in the same cycle ends in PLAY at step 0.
- Tick prescaler:
  - counts only in PLAY and freezes in PAUSE;
  - is cleared in STOP and on restart;
  - asserts `beat` on its terminal count, then reloads.
- `tempo` is sampled at each tick; a change applies to the next tick period.
- Duration counter `dcnt` counts ticks within an entry. On the tick where `dcnt == dur-1`: step increments (6-bit) and dcnt is cleared.
- `track` is sampled only in STOP, on restart, and at a loop wrap. It is held in a register otherwise.
- Output mux:
  - STOP and PAUSE → note 12, octave 0.
  - PLAY → the entry's octave/note.
  - With ARTIC=1 and dur ≥ 2, note 12 is output while `dcnt == dur-1`.
- Reset values: octave 0, note 12, playing 0, beat 0, step 0, state STOP, track register 0.

## Timing
- Outputs are registered, with one cycle of latency from the controlling event:
  - after a play_toggle from STOP, step 0's note appears on the next cycle;
  - after the advancing tick, the next entry's note appears on the next cycle.
- Each entry occupies exactly `dur × (BASE_DIV >> tempo)` PLAY cycles when tempo is constant. Pause cycles do not count.
- Resuming from PAUSE continues the partially elapsed tick; no cycles are lost or added.
- When an advance lands on the end marker, the marker is resolved in the same cycle, so silence is never output for the marker itself:
  - LOOP=1: entry 0 is output next cycle.
  - LOOP=0: note 12 and playing=0 next cycle.
- `beat` is high for exactly one cycle per tick and never in PAUSE or STOP.
- A reset asserted mid-note forces the reset values on the next edge, regardless of other inputs.

## Structure
- Package `melody_pkg` holds:
  - note codes C..B with flat aliases;
  - SILENCE = 12;
  - entry field widths and slice positions;
  - the FSM state enum.
- Sub-module `melody_rom` is a combinational case ROM: inputs (track, step), output a 12-bit entry. It holds both tracks, each terminated by a dur = 0 marker.
- Top of `melody_seq` contains the FSM, prescaler, duration counter, track register and output registers.

## Test plan
Bench uses BASE_DIV = 8 and a test ROM.

Track 0 entries:
- entry 0 = {1, E, 2};
- entry 1 = {0, B, 1};
- entry 2 = {0, 12, 1} (rest);
- entry 3 = end marker.

Track 1 entry 0 = {1, C, 1}.

1. Reset held for 3 cycles → note = 12, octave = 0, playing = 0, step = 0, beat = 0; outputs remain so with no input pulses.
2. ARTIC=0, tempo=0, play_toggle → from next cycle: note = 4 / octave = 1 for 16 cycles, then note = 11 / octave = 0 for 8, then 12 for 8. `beat` pulses every 8 cycles.
3. ARTIC=0, play_toggle again 5 cycles into entry 0 → note = 12 and beat silent for 20 cycles. Resume → entry 0 continues for the remaining 11 cycles (16 PLAY cycles in total).
4. ARTIC=0, tempo = 2 → tick period 2 cycles; entry 0 lasts 4 cycles. A tempo change mid-tick takes effect only after the current tick.
5. After entry 2:
   - LOOP=0 → state STOP, playing = 0, step = 0, note = 12.
   - LOOP=1 → entry 0 follows with no gap; track set to 1 during playback is picked up at the wrap (note = 0).
6. restart and play_toggle in the same cycle while paused → PLAY at step 0. ARTIC=1 → entry 0 outputs note 4 for 8 cycles, then note 12 for 8 cycles.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, ROM entry layout
// and the playback state encoding.
package melody_pkg;

    localparam int OCT_W   = 3;
    localparam int NOTE_W  = 4;
    localparam int DUR_W   = 5;
    localparam int STEP_W  = 6;
    localparam int ENTRY_W = OCT_W + NOTE_W + DUR_W;

    localparam int DUR_LSB  = 0;
    localparam int NOTE_LSB = DUR_LSB + DUR_W;
    localparam int OCT_LSB  = NOTE_LSB + NOTE_W;

    typedef logic [OCT_W-1:0]  oct_t;
    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [DUR_W-1:0]  dur_t;
    typedef logic [STEP_W-1:0] step_t;

    localparam note_t NOTE_C  = 4'd0;
    localparam note_t NOTE_CS = 4'd1;
    localparam note_t NOTE_DB = 4'd1;
    localparam note_t NOTE_D  = 4'd2;
    localparam note_t NOTE_DS = 4'd3;
    localparam note_t NOTE_EB = 4'd3;
    localparam note_t NOTE_E  = 4'd4;
    localparam note_t NOTE_F  = 4'd5;
    localparam note_t NOTE_FS = 4'd6;
    localparam note_t NOTE_GB = 4'd6;
    localparam note_t NOTE_G  = 4'd7;
    localparam note_t NOTE_GS = 4'd8;
    localparam note_t NOTE_AB = 4'd8;
    localparam note_t NOTE_A  = 4'd9;
    localparam note_t NOTE_AS = 4'd10;
    localparam note_t NOTE_BB = 4'd10;
    localparam note_t NOTE_B  = 4'd11;
    localparam note_t SILENCE = 4'd12;

    typedef struct packed {
        oct_t  oct;
        note_t note;
        dur_t  dur;
    } entry_t;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    function automatic entry_t make_entry(input oct_t o, input note_t n, input dur_t d);
        logic [ENTRY_W-1:0] raw;
        raw                      = '0;
        raw[OCT_LSB  +: OCT_W]   = o;
        raw[NOTE_LSB +: NOTE_W]  = n;
        raw[DUR_LSB  +: DUR_W]   = d;
        return entry_t'(raw);
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody store: two tracks of up to 64 entries, each track
// terminated by a zero-duration marker.
module melody_rom
    import melody_pkg::*;
(
    input  logic   track,
    input  step_t  step,
    output entry_t entry
);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        entry = make_entry(3'd0, SILENCE, 5'd0);
        if (track == 1'b0) begin
            case (step)
                6'd0:    entry = make_entry(3'd1, NOTE_E,  5'd2);
                6'd1:    entry = make_entry(3'd0, NOTE_B,  5'd1);
                6'd2:    entry = make_entry(3'd0, SILENCE, 5'd1);
                default: entry = make_entry(3'd0, SILENCE, 5'd0);
            endcase
        end else begin
            case (step)
                6'd0:    entry = make_entry(3'd1, NOTE_C,  5'd1);
                6'd1:    entry = make_entry(3'd1, NOTE_G,  5'd3);
                6'd2:    entry = make_entry(3'd0, NOTE_BB, 5'd2);
                6'd3:    entry = make_entry(3'd1, SILENCE, 5'd1);
                6'd4:    entry = make_entry(3'd2, NOTE_E,  5'd4);
                default: entry = make_entry(3'd0, SILENCE, 5'd0);
            endcase
        end
    end

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: walks the melody ROM at a selectable tempo and drives the
// tone generator's octave/note inputs through registered outputs.
module melody_seq
    import melody_pkg::*;
#(
    parameter int unsigned BASE_DIV = 32'd1 << 22,
    parameter bit          LOOP     = 1'b1,
    parameter bit          ARTIC    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_toggle,
    input  logic              restart,
    input  logic [1:0]        tempo,
    input  logic              track,
    output logic [OCT_W-1:0]  octave,
    output logic [NOTE_W-1:0] note,
    output logic              playing,
    output logic              beat,
    output logic [STEP_W-1:0] step
);

    localparam int PW = $clog2(BASE_DIV);
    typedef logic [PW-1:0] pcnt_t;

    state_e     state_q, state_d;
    pcnt_t      pcnt_q, pcnt_d, term_cnt;
    logic [1:0] tempo_q, tempo_d;
    dur_t       dcnt_q, dcnt_d;
    step_t      step_q, step_d, step_inc;
    logic       track_q, track_d;
    entry_t     entry_q, entry_d, head_entry, next_entry;
    oct_t       octave_q, octave_d;
    note_t      note_q, note_d;
    logic       playing_q, playing_d;
    logic       beat_q, beat_d;
    logic       tick, last_tick, at_marker;

    assign step_inc = step_q + step_t'(1);

    // Entry 0 of the live track input (start, restart, wrap) and the entry
    // following the current one (normal advance, end-marker detection).
    melody_rom u_rom_head (
        .track (track),
        .step  ('0),
        .entry (head_entry)
    );

    melody_rom u_rom_next (
        .track (track_q),
        .step  (step_inc),
        .entry (next_entry)
    );

    always_comb begin
        term_cnt  = pcnt_t'((BASE_DIV >> tempo_q) - 1);
        tick      = (state_q == ST_PLAY) && (pcnt_q == term_cnt);
        last_tick = tick && (dcnt_q == entry_q.dur - dur_t'(1));
        at_marker = last_tick && (next_entry.dur == '0);
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tempo_d = tempo_q;
        dcnt_d  = dcnt_q;
        step_d  = step_q;
        track_d = track_q;
        entry_d = entry_q;

        if (restart) begin
            state_d = ST_PLAY;
            pcnt_d  = '0;
            dcnt_d  = '0;
            step_d  = '0;
            tempo_d = tempo;
            track_d = track;
            entry_d = head_entry;
        end else begin
            case (state_q)
                ST_STOP: begin
                    pcnt_d  = '0;
                    dcnt_d  = '0;
                    step_d  = '0;
                    tempo_d = tempo;
                    track_d = track;
                    entry_d = head_entry;
                    if (play_toggle) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (play_toggle) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    pcnt_d = pcnt_q + pcnt_t'(1);
                    if (play_toggle) begin
                        state_d = ST_PAUSE;
                    end
                    if (tick) begin
                        pcnt_d  = '0;
                        tempo_d = tempo;
                        dcnt_d  = dcnt_q + dur_t'(1);
                    end
                    if (last_tick) begin
                        dcnt_d  = '0;
                        step_d  = step_inc;
                        entry_d = next_entry;
                    end
                    // The marker is never shown: resolve it to entry 0 (or stop) now.
                    if (at_marker) begin
                        step_d  = '0;
                        track_d = track;
                        entry_d = head_entry;
                        if (!LOOP) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    always_comb begin
        octave_d  = entry_d.oct;
        note_d    = entry_d.note;
        playing_d = (state_d == ST_PLAY);
        beat_d    = tick && !restart && (state_d == ST_PLAY);
        if (state_d != ST_PLAY) begin
            octave_d = '0;
            note_d   = SILENCE;
        end else if (ARTIC && (entry_d.dur >= dur_t'(2)) &&
                     (dcnt_d == entry_d.dur - dur_t'(1))) begin
            note_d = SILENCE;
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STOP;
            pcnt_q    <= '0;
            tempo_q   <= '0;
            dcnt_q    <= '0;
            step_q    <= '0;
            track_q   <= 1'b0;
            entry_q   <= '0;
            octave_q  <= '0;
            note_q    <= SILENCE;
            playing_q <= 1'b0;
            beat_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            tempo_q   <= tempo_d;
            dcnt_q    <= dcnt_d;
            step_q    <= step_d;
            track_q   <= track_d;
            entry_q   <= entry_d;
            octave_q  <= octave_d;
            note_q    <= note_d;
            playing_q <= playing_d;
            beat_q    <= beat_d;
        end
    end

    assign octave  = octave_q;
    assign note    = note_q;
    assign playing = playing_q;
    assign beat    = beat_q;
    assign step    = step_q;

endmodule

// File: tb/tb_melody_seq.sv
// Self-checking bench for melody_seq: three parameter variants run side by
// side against a tick/duration countdown model of the melody.
module tb_melody_seq;

    logic            clk, reset, play_toggle, restart, track;
    logic [1:0]      tempo;
    logic [2:0][2:0] oct_o;
    logic [2:0][3:0] note_o;
    logic [2:0]      play_o, beat_o;
    logic [2:0][5:0] step_o;

    int total = 0;
    int bad   = 0;

    // dut0: loop, no articulation; dut1: stop at end; dut2: loop + articulation
    melody_seq #(.BASE_DIV(8), .LOOP(1'b1), .ARTIC(1'b0)) u_a (
        .clk(clk), .reset(reset), .play_toggle(play_toggle), .restart(restart),
        .tempo(tempo), .track(track), .octave(oct_o[0]), .note(note_o[0]),
        .playing(play_o[0]), .beat(beat_o[0]), .step(step_o[0]));
    melody_seq #(.BASE_DIV(8), .LOOP(1'b0), .ARTIC(1'b0)) u_b (
        .clk(clk), .reset(reset), .play_toggle(play_toggle), .restart(restart),
        .tempo(tempo), .track(track), .octave(oct_o[1]), .note(note_o[1]),
        .playing(play_o[1]), .beat(beat_o[1]), .step(step_o[1]));
    melody_seq #(.BASE_DIV(8), .LOOP(1'b1), .ARTIC(1'b1)) u_c (
        .clk(clk), .reset(reset), .play_toggle(play_toggle), .restart(restart),
        .tempo(tempo), .track(track), .octave(oct_o[2]), .note(note_o[2]),
        .playing(play_o[2]), .beat(beat_o[2]), .step(step_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit cfg_loop  [3] = '{1'b1, 1'b0, 1'b1};
    bit cfg_artic [3] = '{1'b0, 1'b0, 1'b1};

    int m_len  [2]    = '{3, 5};
    int m_oct  [2][5] = '{'{1, 0, 0, 0, 0}, '{1, 1, 0, 1, 2}};
    int m_note [2][5] = '{'{4, 11, 12, 0, 0}, '{0, 7, 10, 12, 4}};
    int m_dur  [2][5] = '{'{2, 1, 1, 0, 0}, '{1, 3, 2, 1, 4}};

    // Model: st 0=stop 1=play 2=pause; lc = play cycles left in the tick,
    // lt = ticks left in the note.
    int m_st [3], m_idx [3], m_trk [3], m_tmp [3], m_lc [3], m_lt [3];
    bit m_beat [3];

    always @(posedge clk) begin : model
        int st, idx, trk, tmp, lc, lt;
        bit tk;
        for (int k = 0; k < 3; k++) begin
            st = m_st[k]; idx = m_idx[k]; trk = m_trk[k];
            tmp = m_tmp[k]; lc = m_lc[k]; lt = m_lt[k]; tk = 1'b0;
            if (reset) begin
                st = 0; idx = 0; trk = 0; tmp = 0; lc = 0; lt = 0;
            end else if (restart) begin
                st = 1; idx = 0; trk = int'(track); tmp = int'(tempo);
                lc = 8 >> tmp; lt = m_dur[trk][0];
            end else if (st == 0) begin
                trk = int'(track); tmp = int'(tempo);
                if (play_toggle) begin
                    st = 1; idx = 0; lc = 8 >> tmp; lt = m_dur[trk][0];
                end
            end else if (st == 2) begin
                if (play_toggle) st = 1;
            end else begin
                lc = lc - 1;
                if (lc == 0) begin
                    tk = 1'b1; tmp = int'(tempo); lc = 8 >> tmp; lt = lt - 1;
                    if (lt == 0) begin
                        idx = idx + 1;
                        if (idx == m_len[trk]) begin
                            idx = 0; trk = int'(track);
                            if (!cfg_loop[k]) st = 0;
                        end
                        lt = m_dur[trk][idx];
                    end
                end
                if (play_toggle && st == 1) st = 2;
            end
            m_st[k] <= st; m_idx[k] <= idx; m_trk[k] <= trk;
            m_tmp[k] <= tmp; m_lc[k] <= lc; m_lt[k] <= lt;
            m_beat[k] <= tk && (st == 1);
        end
    end

    function automatic logic [14:0] obs(input int k);
        return {oct_o[k], note_o[k], play_o[k], beat_o[k], step_o[k]};
    endfunction

    function automatic logic [14:0] exp_vec(input int k);
        logic [2:0] o;
        logic [3:0] n;
        o = 3'd0;
        n = 4'd12;
        if (m_st[k] == 1) begin
            o = 3'(m_oct[m_trk[k]][m_idx[k]]);
            n = 4'(m_note[m_trk[k]][m_idx[k]]);
            if (cfg_artic[k] && m_dur[m_trk[k]][m_idx[k]] >= 2 && m_lt[k] == 1) n = 4'd12;
        end
        return {o, n, (m_st[k] == 1), m_beat[k], 6'(m_idx[k])};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; play_toggle = 1'b0; restart = 1'b0;
        tempo = 2'd0; track = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] rst_val;
        rst_val = {3'd0, 4'd12, 1'b0, 1'b0, 6'd0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            total++;
            if (obs(0) !== rst_val || obs(1) !== rst_val || obs(2) !== rst_val) begin
                bad++;
                $display("FAIL reset c=%0d got=%h/%h/%h want=%h", c, obs(0), obs(1), obs(2), rst_val);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL reset_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            if (c == 2) reset = 1'b0;
        end
    endtask

    task automatic test_play();
        logic [3:0] lit;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL play_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            if (c >= 1 && c <= 33) begin
                lit = (c <= 16) ? 4'd4 : (c <= 24) ? 4'd11 : (c <= 32) ? 4'd12 : 4'd4;
                total++;
                if (note_o[0] !== lit) begin
                    bad++;
                    $display("FAIL play_note c=%0d got=%0d want=%0d", c, note_o[0], lit);
                end
            end
            if (c >= 2 && c <= 33) begin
                total++;
                if (beat_o[0] !== (c % 8 == 1)) begin
                    bad++;
                    $display("FAIL play_beat c=%0d got=%0b want=%0b", c, beat_o[0], (c % 8 == 1));
                end
            end
            play_toggle = (c == 0);
        end
    endtask

    task automatic test_pause();
        logic [3:0] lit;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL pause_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            if (c >= 1 && c <= 37) begin
                lit = (c <= 5) ? 4'd4 : (c <= 25) ? 4'd12 : (c <= 36) ? 4'd4 : 4'd11;
                total++;
                if (note_o[0] !== lit || (c >= 6 && c <= 25 && beat_o[0] !== 1'b0)) begin
                    bad++;
                    $display("FAIL pause_note c=%0d got=%0d beat=%0b want=%0d", c, note_o[0], beat_o[0], lit);
                end
            end
            play_toggle = (c == 0) || (c == 5) || (c == 25);
        end
    endtask

    task automatic test_tempo();
        logic [3:0] lit;
        apply_reset();
        tempo = 2'd2;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL tempo_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            if (c >= 1 && c <= 19) begin
                lit = (c <= 4) ? 4'd4 : (c <= 6) ? 4'd11 : (c <= 8) ? 4'd12 :
                      (c <= 14) ? 4'd4 : (c <= 18) ? 4'd11 : 4'd12;
                total++;
                if (note_o[0] !== lit) begin
                    bad++;
                    $display("FAIL tempo_note c=%0d got=%0d want=%0d", c, note_o[0], lit);
                end
            end
            play_toggle = (c == 0);
            if (c == 9) tempo = 2'd1;
        end
    endtask

    task automatic test_end_of_melody();
        apply_reset();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL end_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            if (c == 32) begin
                total++;
                if (play_o[1] !== 1'b1 || step_o[1] !== 6'd2 || note_o[1] !== 4'd12) begin
                    bad++;
                    $display("FAIL end_rest got play=%0b step=%0d note=%0d want 1/2/12", play_o[1], step_o[1], note_o[1]);
                end
            end
            if (c == 33 || c == 34) begin
                total++;
                if (play_o[1] !== 1'b0 || step_o[1] !== 6'd0 || note_o[1] !== 4'd12 || oct_o[1] !== 3'd0) begin
                    bad++;
                    $display("FAIL end_stop c=%0d got play=%0b step=%0d note=%0d oct=%0d want 0/0/12/0",
                             c, play_o[1], step_o[1], note_o[1], oct_o[1]);
                end
                total++;
                if (play_o[0] !== 1'b1 || step_o[0] !== 6'd0 || note_o[0] !== 4'd0 || oct_o[0] !== 3'd1) begin
                    bad++;
                    $display("FAIL end_wrap c=%0d got play=%0b step=%0d note=%0d oct=%0d want 1/0/0/1",
                             c, play_o[0], step_o[0], note_o[0], oct_o[0]);
                end
            end
            play_toggle = (c == 0);
            if (c == 10) track = 1'b1;
        end
        track = 1'b0;
    endtask

    task automatic test_restart_toggle();
        logic [3:0] lit;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL restart_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            if (c >= 9 && c <= 25) begin
                lit = (c <= 16) ? 4'd4 : (c <= 24) ? 4'd12 : 4'd11;
                total++;
                if (note_o[2] !== lit || play_o[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL restart_artic c=%0d got note=%0d play=%0b want note=%0d play=1", c, note_o[2], play_o[2], lit);
                end
                lit = (c <= 24) ? 4'd4 : 4'd11;
                total++;
                if (note_o[0] !== lit) begin
                    bad++;
                    $display("FAIL restart_plain c=%0d got=%0d want=%0d", c, note_o[0], lit);
                end
            end
            play_toggle = (c == 0) || (c == 3) || (c == 8);
            restart     = (c == 8);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs(k) !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL random_model c=%0d dut%0d got=%h want=%h", c, k, obs(k), exp_vec(k));
                end
            end
            play_toggle = ($urandom_range(15) == 0);
            restart     = ($urandom_range(63) == 0);
            reset       = ($urandom_range(399) == 0);
            if ($urandom_range(31) == 0) tempo = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) track = ~track;
        end
        play_toggle = 1'b0; restart = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; play_toggle = 1'b0; restart = 1'b0;
        tempo = 2'd0; track = 1'b0;
        test_reset();
        test_play();
        test_pause();
        test_tempo();
        test_end_of_melody();
        test_restart_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
